// File: rtl/tsu_q_drain_pkg.sv
// Shared definitions for the timestamp-queue drain sequencer: register map,
// request/ok bit positions, fixed wait length and FSM encodings.
// Build option: TSU_Q_DRAIN_TX_EN enables draining of the TX queue as well as RX.
package tsu_q_drain_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h40;
    localparam logic [7:0] ADDR_RX_LVL  = 8'h44;
    localparam logic [7:0] ADDR_TX_LVL  = 8'h48;
    localparam logic [7:0] ADDR_RX_DATA = 8'h60;
    localparam logic [7:0] ADDR_TX_DATA = 8'h70;

    localparam int unsigned BIT_RX = 2;
    localparam int unsigned BIT_TX = 0;

    // Clocks held after raising a request so the old ok clears and the new ok sets.
    localparam logic [7:0] WAIT_LEN = 8'd6;
    // Idle clocks between successive ok polls.
    localparam logic [7:0] CHK_GAP  = 8'd2;

    typedef enum logic [3:0] {
        IDLE,
        STAT,
        GAP,
        REQ_CLR,
        REQ_SET,
        WAIT,
        CHK,
        DATA,
        OUT
    } state_t;

    // Sub-phase of a bus access inside STAT/CHK/DATA.
    typedef enum logic [1:0] {
        PH_STROBE,
        PH_SAMPLE,
        PH_PAUSE
    } phase_t;

    typedef enum logic {
        Q_RX = 1'b0,
        Q_TX = 1'b1
    } queue_t;

    function automatic logic [7:0] lvl_addr(input queue_t q);
        return (q == Q_TX) ? ADDR_TX_LVL : ADDR_RX_LVL;
    endfunction

    function automatic logic [7:0] data_base(input queue_t q);
        return (q == Q_TX) ? ADDR_TX_DATA : ADDR_RX_DATA;
    endfunction

    // Control word with only the queue's read-request bit set; reset bits stay 0.
    function automatic logic [31:0] req_word(input queue_t q);
        logic [31:0] w;
        w = '0;
        if (q == Q_TX) w[BIT_TX] = 1'b1;
        else           w[BIT_RX] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/tsu_q_drain_bus.sv
// Bus-access engine: turns a one-cycle read/write command into a single-cycle
// strobe on the register bus and flags the read data one clock later.
module tsu_q_drain_bus
    import tsu_q_drain_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rd,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data
);

    logic pend_q;

    // Remember that a read was issued so its data is flagged on the next clock.
    always_ff @(posedge clk) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= bus_rd;
    end

    // Drive the strobe; address and data are forced to zero when no access is made.
    always_comb begin
        bus_wr    = cmd_wr;
        bus_rd    = cmd_rd & ~cmd_wr;
        bus_addr  = (cmd_wr | cmd_rd) ? cmd_addr : '0;
        bus_wdata = cmd_wr ? cmd_wdata : '0;
    end

    assign rsp_valid = pend_q;
    assign rsp_data  = bus_rdata;

endmodule

// File: rtl/tsu_q_drain.sv
// Timestamp-queue drain sequencer: polls the RX (and optionally TX) queue fill
// levels, performs the request/ok handshake on register 0x40, reads the four
// data words and presents each 128-bit record on a valid/ready port.
// Build option: TSU_Q_DRAIN_TX_EN serves both queues round-robin; otherwise RX only.
module tsu_q_drain
    import tsu_q_drain_pkg::*;
#(
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned OK_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    output logic         bus_wr,
    output logic         bus_rd,
    output logic [7:0]   bus_addr,
    output logic [31:0]  bus_wdata,
    input  logic [31:0]  bus_rdata,
    output logic         ts_valid,
    input  logic         ts_ready,
    output logic [127:0] ts_data,
    output logic         ts_src,
    output logic         busy,
    output logic         err_timeout,
    input  logic         err_clr
);

    localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);
    localparam logic [7:0] TRY_LIMIT = 8'(OK_TIMEOUT);

    state_t       state, state_nx;
    phase_t       ph, ph_nx;
    logic [1:0]   idx, idx_nx;
    logic [7:0]   cnt, cnt_nx;
    logic [7:0]   tries, tries_nx, tries_inc;
    queue_t       cur, cur_nx;
    logic [127:0] rec, rec_nx;
    logic         err, err_set;

    logic         cmd_rd, cmd_wr;
    logic [7:0]   cmd_addr;
    logic [31:0]  cmd_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_data;

    queue_t       qsel;
    logic         stat_last;
    logic         lvl_nz;
    logic         ok_bit;

`ifdef TSU_Q_DRAIN_TX_EN
    queue_t rr_ptr, rr_nx;
    assign qsel      = (idx[0] == 1'b0) ? rr_ptr : ((rr_ptr == Q_RX) ? Q_TX : Q_RX);
    assign stat_last = idx[0];
`else
    assign qsel      = Q_RX;
    assign stat_last = 1'b1;
`endif

    assign lvl_nz    = (rsp_data[7:0] != 8'd0);
    assign ok_bit    = (cur == Q_TX) ? rsp_data[BIT_TX] : rsp_data[BIT_RX];
    assign tries_inc = (tries == 8'hFF) ? tries : tries + 8'd1;

    tsu_q_drain_bus u_bus (
        .clk       (clk),
        .rst       (rst),
        .cmd_rd    (cmd_rd),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    // State register and sequencing datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ph    <= PH_STROBE;
            idx   <= '0;
            cnt   <= '0;
            tries <= '0;
            cur   <= Q_RX;
            rec   <= '0;
`ifdef TSU_Q_DRAIN_TX_EN
            rr_ptr <= Q_RX;
`endif
        end else begin
            state <= state_nx;
            ph    <= ph_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            tries <= tries_nx;
            cur   <= cur_nx;
            rec   <= rec_nx;
`ifdef TSU_Q_DRAIN_TX_EN
            rr_ptr <= rr_nx;
`endif
        end
    end

    // Sticky timeout flag; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst)          err <= 1'b0;
        else if (err_clr) err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    // Next-state and next-datapath decisions.
    always_comb begin
        state_nx = state;
        ph_nx    = ph;
        idx_nx   = idx;
        cnt_nx   = cnt;
        tries_nx = tries;
        cur_nx   = cur;
        rec_nx   = rec;
        err_set  = 1'b0;
`ifdef TSU_Q_DRAIN_TX_EN
        rr_nx    = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = STAT;
                    ph_nx    = PH_STROBE;
                    idx_nx   = '0;
                end
            end
            STAT: begin
                if (ph == PH_STROBE) begin
                    ph_nx = PH_SAMPLE;
                end else if (rsp_valid) begin
                    if (lvl_nz) begin
                        cur_nx = qsel;
`ifdef TSU_Q_DRAIN_TX_EN
                        state_nx = REQ_CLR;
`else
                        // RX-only: the clearing write is issued in this sample cycle.
                        state_nx = REQ_SET;
`endif
                    end else if (stat_last) begin
                        state_nx = GAP;
                        cnt_nx   = '0;
                    end else begin
                        idx_nx = idx + 2'd1;
                        ph_nx  = PH_STROBE;
                    end
                end
            end
            GAP: begin
                if (cnt >= GAP_LAST) state_nx = IDLE;
                else                 cnt_nx   = cnt + 8'd1;
            end
            REQ_CLR: begin
                state_nx = REQ_SET;
            end
            REQ_SET: begin
                state_nx = WAIT;
                cnt_nx   = '0;
                tries_nx = '0;
            end
            WAIT: begin
                if (cnt == WAIT_LEN - 8'd1) begin
                    state_nx = CHK;
                    ph_nx    = PH_STROBE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            CHK: begin
                case (ph)
                    PH_STROBE: ph_nx = PH_SAMPLE;
                    PH_SAMPLE: begin
                        if (rsp_valid) begin
                            if (ok_bit) begin
                                state_nx = DATA;
                                ph_nx    = PH_STROBE;
                                idx_nx   = '0;
                            end else if (tries_inc >= TRY_LIMIT) begin
                                err_set  = 1'b1;
                                state_nx = IDLE;
`ifdef TSU_Q_DRAIN_TX_EN
                                rr_nx    = (rr_ptr == Q_RX) ? Q_TX : Q_RX;
`endif
                            end else begin
                                tries_nx = tries_inc;
                                ph_nx    = PH_PAUSE;
                                cnt_nx   = '0;
                            end
                        end
                    end
                    default: begin
                        if (cnt == CHK_GAP - 8'd1) ph_nx  = PH_STROBE;
                        else                       cnt_nx = cnt + 8'd1;
                    end
                endcase
            end
            DATA: begin
                if (ph == PH_STROBE) begin
                    ph_nx = PH_SAMPLE;
                end else if (rsp_valid) begin
                    rec_nx = {rec[95:0], rsp_data};
                    if (idx == 2'd3) begin
                        state_nx = OUT;
                    end else begin
                        idx_nx = idx + 2'd1;
                        ph_nx  = PH_STROBE;
                    end
                end
            end
            OUT: begin
                if (ts_ready) begin
                    state_nx = IDLE;
`ifdef TSU_Q_DRAIN_TX_EN
                    rr_nx    = (rr_ptr == Q_RX) ? Q_TX : Q_RX;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus commands and streaming outputs decoded from the current state.
    always_comb begin
        cmd_rd    = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        case (state)
            STAT: begin
                if (ph == PH_STROBE) begin
                    cmd_rd   = 1'b1;
                    cmd_addr = lvl_addr(qsel);
                end
`ifndef TSU_Q_DRAIN_TX_EN
                else if (rsp_valid && lvl_nz) begin
                    cmd_wr   = 1'b1;
                    cmd_addr = ADDR_CTRL;
                end
`endif
            end
            REQ_CLR: begin
                cmd_wr   = 1'b1;
                cmd_addr = ADDR_CTRL;
            end
            REQ_SET: begin
                cmd_wr    = 1'b1;
                cmd_addr  = ADDR_CTRL;
                cmd_wdata = req_word(cur);
            end
            CHK: begin
                if (ph == PH_STROBE) begin
                    cmd_rd   = 1'b1;
                    cmd_addr = ADDR_CTRL;
                end
            end
            DATA: begin
                if (ph == PH_STROBE) begin
                    cmd_rd   = 1'b1;
                    cmd_addr = data_base(cur) + {4'd0, idx, 2'b00};
                end
            end
            default: ;
        endcase

        ts_valid    = (state == OUT);
        ts_data     = rec;
        busy        = (state != IDLE);
        err_timeout = err;
`ifdef TSU_Q_DRAIN_TX_EN
        ts_src      = (cur == Q_TX);
`else
        ts_src      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_tsu_q_drain.sv
// Directed testbench for tsu_q_drain with a small register-block model.
// Build option: TSU_Q_DRAIN_TX_EN selects the two-queue expectations.
`timescale 1ns/1ps
module tb_tsu_q_drain;

    localparam int unsigned POLL_GAP   = 5;
    localparam int unsigned OK_TIMEOUT = 4;

    localparam logic [127:0] RX_REC  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] TX_REC  = 128'hA0000001_A0000002_A0000003_A0000004;
    localparam logic [127:0] RX_REC2 = 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004;

`ifdef TSU_Q_DRAIN_TX_EN
    localparam int unsigned  EXP_LAT    = 20;
    localparam int unsigned  EXP_PERIOD = POLL_GAP + 5;
    localparam int unsigned  EXP_RD48   = 3;
    localparam logic [31:0]  EXP_WR [6] = '{32'h0, 32'h4, 32'h0, 32'h1, 32'h0, 32'h4};
    localparam logic         EXP_SRC[3] = '{1'b0, 1'b1, 1'b0};
    localparam logic [127:0] EXP_REC[3] = '{RX_REC, TX_REC, RX_REC};
`else
    localparam int unsigned  EXP_LAT    = 19;
    localparam int unsigned  EXP_PERIOD = POLL_GAP + 3;
    localparam int unsigned  EXP_RD48   = 0;
    localparam logic [31:0]  EXP_WR [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h4};
    localparam logic         EXP_SRC[3] = '{1'b0, 1'b0, 1'b0};
    localparam logic [127:0] EXP_REC[3] = '{RX_REC, RX_REC, RX_REC};
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         bus_wr, bus_rd;
    logic [7:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata = '0;
    logic         ts_valid;
    logic         ts_ready = 1'b0;
    logic [127:0] ts_data;
    logic         ts_src;
    logic         busy;
    logic         err_timeout;
    logic         err_clr = 1'b0;

    tsu_q_drain #(
        .POLL_GAP   (POLL_GAP),
        .OK_TIMEOUT (OK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .ts_valid    (ts_valid),
        .ts_ready    (ts_ready),
        .ts_data     (ts_data),
        .ts_src      (ts_src),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-block model: levels, data words and edge-free ok flags.
    logic [7:0]  rx_lvl = '0, tx_lvl = '0;
    logic [31:0] rx_w[4];
    logic [31:0] tx_w[4];
    logic        ok_never = 1'b0;
    logic        rx_ok = 1'b0, tx_ok = 1'b0;

    function automatic logic [31:0] reg_read(input logic [7:0] a);
        case (a)
            8'h40: return {29'd0, rx_ok, 1'b0, tx_ok};
            8'h44: return {24'd0, rx_lvl};
            8'h48: return {24'd0, tx_lvl};
            8'h60, 8'h64, 8'h68, 8'h6C: return rx_w[a[3:2]];
            8'h70, 8'h74, 8'h78, 8'h7C: return tx_w[a[3:2]];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus_wr && bus_addr == 8'h40) begin
            rx_ok <= !ok_never && bus_wdata[2];
            tx_ok <= !ok_never && bus_wdata[0];
        end
        if (bus_rd) bus_rdata <= reg_read(bus_addr);
    end

    // Bus activity log, sampled mid-cycle.
    int unsigned n_strobe = 0, n_rd40 = 0, n_rd44 = 0, n_rd48 = 0;
    logic [31:0] wr_log[$];
    logic [7:0]  drd_log[$];
    int unsigned rd44_t[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_rd || bus_wr) n_strobe++;
            if (bus_wr && bus_addr == 8'h40) wr_log.push_back(bus_wdata);
            if (bus_rd) begin
                case (bus_addr)
                    8'h40: n_rd40++;
                    8'h44: begin n_rd44++; rd44_t.push_back(cyc); end
                    8'h48: n_rd48++;
                    default: drd_log.push_back(bus_addr);
                endcase
            end
        end
    end

    int unsigned n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        n_strobe = 0; n_rd40 = 0; n_rd44 = 0; n_rd48 = 0;
        wr_log.delete(); drd_log.delete(); rd44_t.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) tick();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    // Count rising edges until ts_valid is seen.
    task automatic wait_valid(input string tag, output int unsigned n);
        n = 0;
        while (!ts_valid && n < 400) begin
            @(posedge clk);
            n++;
            tick();
        end
        check({tag, "_valid"}, ts_valid, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},    bus_rd, 1'b0);
        check({tag, "_wr"},    bus_wr, 1'b0);
        check({tag, "_addr"},  bus_addr, 8'h00);
        check({tag, "_wdata"}, bus_wdata, 32'h0);
        check({tag, "_valid"}, ts_valid, 1'b0);
        check({tag, "_data"},  ts_data, 128'h0);
        check({tag, "_src"},   ts_src, 1'b0);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_err"},   err_timeout, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat, n_valid_hold, n_bad, s0, nrec;
        logic [127:0] d0;
        logic         got_src[3];
        logic [127:0] got_rec[3];

        rx_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tx_w = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};

        // Reset values
        do_reset();
        check_all_zero("reset");

        // Empty queues: status polls only, periodic, no control writes
        rx_lvl = 8'd0; tx_lvl = 8'd0;
        enable = 1'b1;
        for (int i = 0; i < 200 && rd44_t.size() < 3; i++) tick();
        enable = 1'b0;
        wait_idle("empty");
        check("empty_rd44", n_rd44, 3);
        check("empty_rd48", n_rd48, EXP_RD48);
        check("empty_wr", wr_log.size(), 0);
        check("empty_rd40", n_rd40, 0);
        if (rd44_t.size() < 3) begin
            rd44_t.push_back(0); rd44_t.push_back(0); rd44_t.push_back(0);
        end
        check("empty_period0", rd44_t[1] - rd44_t[0], EXP_PERIOD);
        check("empty_period1", rd44_t[2] - rd44_t[1], EXP_PERIOD);

        // Single RX record: latency, contents, then stall with ready low
        clear_logs();
        rx_lvl = 8'd3; tx_lvl = 8'd0;
        ts_ready = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        wait_valid("rx1", lat);
        check("rx1_latency", lat, EXP_LAT);
        check("rx1_data", ts_data, RX_REC);
        check("rx1_src", ts_src, 1'b0);
        check("rx1_words", drd_log.size(), 4);

        s0 = n_strobe; d0 = ts_data; n_valid_hold = 0; n_bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ts_valid) n_valid_hold++;
            if (ts_data !== d0 || ts_src !== 1'b0) n_bad++;
        end
        check("stall_valid_cycles", n_valid_hold, 50);
        check("stall_data_changes", n_bad, 0);
        check("stall_strobes", n_strobe - s0, 0);
        ts_ready = 1'b1;
        enable = 1'b0;
        tick();
        check("rx1_accept", ts_valid, 1'b0);
        ts_ready = 1'b0;
        wait_idle("rx1");

        // Both queues non-empty with ready high: round-robin order and 0x40 writes
        do_reset();
        rx_lvl = 8'd3; tx_lvl = 8'd3;
        ts_ready = 1'b1;
        got_src = '{1'bx, 1'bx, 1'bx};
        got_rec = '{128'hx, 128'hx, 128'hx};
        nrec = 0;
        enable = 1'b1;
        for (int i = 0; i < 400 && nrec < 3; i++) begin
            tick();
            if (ts_valid && ts_ready) begin
                got_src[nrec] = ts_src;
                got_rec[nrec] = ts_data;
                nrec++;
                if (nrec == 3) enable = 1'b0;
            end
        end
        enable = 1'b0;
        tick();
        ts_ready = 1'b0;
        wait_idle("rr");
        check("rr_count", nrec, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rr_src%0d", i), got_src[i], EXP_SRC[i]);
            check($sformatf("rr_data%0d", i), got_rec[i], EXP_REC[i]);
        end
        check("rr_wr_count", wr_log.size(), 6);
        while (wr_log.size() < 6) wr_log.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++)
            check($sformatf("rr_wr%0d", i), wr_log[i], EXP_WR[i]);

        // ok never sets: timeout after OK_TIMEOUT polls, enable pulse only
        do_reset();
        ok_never = 1'b1;
        rx_lvl = 8'd3; tx_lvl = 8'd0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 400 && !err_timeout; i++) tick();
        check("to_err", err_timeout, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_rd40", n_rd40, OK_TIMEOUT);
        check("to_wr_count", wr_log.size(), 2);
        check("to_words", drd_log.size(), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr", err_timeout, 1'b0);

        // Clear held through a second timeout wins over the set
        clear_logs();
        err_clr = 1'b1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_idle("to2");
        check("to2_rd40", n_rd40, OK_TIMEOUT);
        check("to2_err", err_timeout, 1'b0);
        err_clr = 1'b0;
        tick();
        check("to2_err_after", err_timeout, 1'b0);

        // Reset in the middle of DATA, then a fresh full fetch (level 0xFF)
        do_reset();
        ok_never = 1'b0;
        rx_lvl = 8'hFF; tx_lvl = 8'd0;
        enable = 1'b1;
        for (int i = 0; i < 400 && drd_log.size() < 2; i++) tick();
        tick();
        rst = 1'b1;
        enable = 1'b0;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        rx_w = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
        clear_logs();
        enable = 1'b1;
        @(posedge clk);
        wait_valid("rerun", lat);
        check("rerun_latency", lat, EXP_LAT);
        check("rerun_data", ts_data, RX_REC2);
        check("rerun_words", drd_log.size(), 4);
        while (drd_log.size() < 4) drd_log.push_back(8'hFF);
        for (int i = 0; i < 4; i++)
            check($sformatf("rerun_addr%0d", i), drd_log[i], 8'h60 + 8'(4 * i));
        ts_ready = 1'b1;
        enable = 1'b0;
        tick();
        ts_ready = 1'b0;
        wait_idle("rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
